// File: rtl/sys_ctrl_pkg.sv
// UART_pkg: shared byte width, ALU opcodes, sys_ctrl command bytes, FSM states
// and the fixed operand register addresses used by the command sequencer.
package UART_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      Addition       = 4'd0,
      Subtraction    = 4'd1,
      Multiplication = 4'd2,
      Division       = 4'd3,
      Logic_and      = 4'd4,
      Logic_or       = 4'd5,
      Logic_nand     = 4'd6,
      Logic_nor      = 4'd7,
      Logic_xor      = 4'd8,
      Logic_xnor     = 4'd9,
      Cmp_gt         = 4'd10,
      SHIFTR         = 4'd11
   } Alu_op_e;

   localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA;
   localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

   localparam logic [3:0] OPA_ADDR = 4'd0;
   localparam logic [3:0] OPB_ADDR = 4'd1;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OP_A     = 4'd5,
      OP_B     = 4'd6,
      OP_FUN   = 4'd7,
      ALU_FIRE = 4'd8,
      ALU_WAIT = 4'd9,
      TX_LO    = 4'd10,
      TX_HI    = 4'd11,
      TX_RD    = 4'd12
   } sys_ctrl_state_e;

   // States that are waiting for the next byte of a partially received frame.
   function automatic logic is_mid_frame(input sys_ctrl_state_e st);
      case (st)
         WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN: is_mid_frame = 1'b1;
         default:                                       is_mid_frame = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between sys_ctrl (master) and the UART RX/TX, register file and ALU (slave).
interface sys_ctrl_if
   import UART_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) ();

   logic [DATA_WIDTH-1:0]   RX_DATA;
   logic                    RX_VALID;
   logic [ADDR_WIDTH-1:0]   RF_ADDR;
   logic                    RF_WR_EN;
   logic [DATA_WIDTH-1:0]   RF_WR_DATA;
   logic                    RF_RD_EN;
   logic [DATA_WIDTH-1:0]   RF_RD_DATA;
   logic                    RF_RD_VALID;
   logic                    ALU_EN;
   Alu_op_e                 ALU_FUN;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VALID;
   logic [DATA_WIDTH-1:0]   TX_DATA;
   logic                    TX_VALID;
   logic                    TX_READY;
   logic                    BUSY;

   modport master (
      input  RX_DATA, RX_VALID, RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
      output RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, TX_DATA, TX_VALID, BUSY
   );

   modport slave (
      output RX_DATA, RX_VALID, RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
      input  RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, TX_DATA, TX_VALID, BUSY
   );

endinterface

// File: rtl/sys_ctrl_tx_ser.sv
// TX serialiser: sends a 1- or 2-byte payload low byte first, holding TX_VALID
// and the byte steady until each TX_VALID && TX_READY handshake.
module sys_ctrl_tx_ser
   import UART_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start_s,
   input  logic                    two_byte_s,
   input  logic [2*DATA_WIDTH-1:0] payload_s,
   input  logic                    tx_ready_s,
   output logic [DATA_WIDTH-1:0]   tx_data_r,
   output logic                    tx_valid_r,
   output logic                    hs_s
);

   logic [DATA_WIDTH-1:0] hi_byte_r;
   logic                  pend_hi_r;

   assign hs_s = tx_valid_r & tx_ready_s;

   // Payload load, byte advance on handshake, release after the last byte.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_data_r  <= {DATA_WIDTH{1'b0}};
         tx_valid_r <= 1'b0;
         hi_byte_r  <= {DATA_WIDTH{1'b0}};
         pend_hi_r  <= 1'b0;
      end else if (start_s) begin
         tx_data_r  <= payload_s[DATA_WIDTH-1:0];
         hi_byte_r  <= payload_s[2*DATA_WIDTH-1:DATA_WIDTH];
         pend_hi_r  <= two_byte_s;
         tx_valid_r <= 1'b1;
      end else if (hs_s) begin
         if (pend_hi_r) begin
            tx_data_r <= hi_byte_r;
            pend_hi_r <= 1'b0;
         end else begin
            tx_valid_r <= 1'b0;
         end
      end else begin
         tx_valid_r <= tx_valid_r;
      end
   end

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer between UART and register file / ALU.
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl
   import UART_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   sys_ctrl_if.master  bus
);

   sys_ctrl_state_e         state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
   Alu_op_e                 alu_fun_r, fun_nxt_s;
   logic [ADDR_WIDTH-1:0]   rf_addr_r, rf_addr_s;
   logic [DATA_WIDTH-1:0]   rf_wr_data_r, wr_data_s;
   logic                    rf_wr_en_r, wr_en_s;
   logic                    rf_rd_en_r, rd_en_s;
   logic                    alu_en_r, alu_en_s;
   logic                    busy_r;
   logic                    ser_start_s, ser_two_s, ser_hs_s;
   logic [2*DATA_WIDTH-1:0] ser_payload_s;
   logic                    tmo_hit_s;

`ifdef SYS_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             mid_s;

   assign mid_s     = is_mid_frame(state_r);
   assign tmo_hit_s = mid_s & ~bus.RX_VALID & (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter, cleared by every byte and outside mid-frame states.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (!mid_s || bus.RX_VALID) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Frame parser: next state, strobes and serialiser requests.
   always_comb begin
      state_nxt_s   = state_r;
      addr_nxt_s    = addr_r;
      fun_nxt_s     = alu_fun_r;
      rf_addr_s     = rf_addr_r;
      wr_data_s     = rf_wr_data_r;
      wr_en_s       = 1'b0;
      rd_en_s       = 1'b0;
      ser_start_s   = 1'b0;
      ser_two_s     = 1'b0;
      ser_payload_s = {(2*DATA_WIDTH){1'b0}};
      case (state_r)
         IDLE: begin
            if (bus.RX_VALID) begin
               case (bus.RX_DATA)
                  CMD_RF_WR:   state_nxt_s = WR_ADDR;
                  CMD_RF_RD:   state_nxt_s = RD_ADDR;
                  CMD_ALU_OP:  state_nxt_s = OP_A;
                  CMD_ALU_NOP: state_nxt_s = OP_FUN;
                  default:     state_nxt_s = IDLE;
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WR_ADDR: begin
            if (bus.RX_VALID) begin
               addr_nxt_s  = bus.RX_DATA[ADDR_WIDTH-1:0];
               state_nxt_s = WR_DATA;
            end else begin
               state_nxt_s = WR_ADDR;
            end
         end
         WR_DATA: begin
            if (bus.RX_VALID) begin
               wr_en_s     = 1'b1;
               rf_addr_s   = addr_r;
               wr_data_s   = bus.RX_DATA;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WR_DATA;
            end
         end
         RD_ADDR: begin
            if (bus.RX_VALID) begin
               rd_en_s     = 1'b1;
               rf_addr_s   = bus.RX_DATA[ADDR_WIDTH-1:0];
               state_nxt_s = RD_WAIT;
            end else begin
               state_nxt_s = RD_ADDR;
            end
         end
         RD_WAIT: begin
            if (bus.RF_RD_VALID) begin
               ser_start_s   = 1'b1;
               ser_payload_s = {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
               state_nxt_s   = TX_RD;
            end else begin
               state_nxt_s = RD_WAIT;
            end
         end
         OP_A: begin
            if (bus.RX_VALID) begin
               wr_en_s     = 1'b1;
               rf_addr_s   = ADDR_WIDTH'(OPA_ADDR);
               wr_data_s   = bus.RX_DATA;
               state_nxt_s = OP_B;
            end else begin
               state_nxt_s = OP_A;
            end
         end
         OP_B: begin
            if (bus.RX_VALID) begin
               wr_en_s     = 1'b1;
               rf_addr_s   = ADDR_WIDTH'(OPB_ADDR);
               wr_data_s   = bus.RX_DATA;
               state_nxt_s = OP_FUN;
            end else begin
               state_nxt_s = OP_B;
            end
         end
         OP_FUN: begin
            // Codes 12..15 have no ALU operation; the command is dropped.
            if (bus.RX_VALID) begin
               if (bus.RX_DATA[3:0] > SHIFTR) begin
                  state_nxt_s = IDLE;
               end else begin
                  fun_nxt_s   = Alu_op_e'(bus.RX_DATA[3:0]);
                  state_nxt_s = ALU_FIRE;
               end
            end else begin
               state_nxt_s = OP_FUN;
            end
         end
         ALU_FIRE: state_nxt_s = ALU_WAIT;
         ALU_WAIT: begin
            if (bus.ALU_OUT_VALID) begin
               ser_start_s   = 1'b1;
               ser_two_s     = 1'b1;
               ser_payload_s = bus.ALU_OUT;
               state_nxt_s   = TX_LO;
            end else begin
               state_nxt_s = ALU_WAIT;
            end
         end
         TX_LO: begin
            if (ser_hs_s) begin
               state_nxt_s = TX_HI;
            end else begin
               state_nxt_s = TX_LO;
            end
         end
         TX_HI, TX_RD: begin
            if (ser_hs_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      if (tmo_hit_s) begin
         state_nxt_s = IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   assign alu_en_s = (state_nxt_s == ALU_FIRE);

   // State and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r      <= IDLE;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         alu_fun_r    <= Addition;
         rf_addr_r    <= {ADDR_WIDTH{1'b0}};
         rf_wr_data_r <= {DATA_WIDTH{1'b0}};
         rf_wr_en_r   <= 1'b0;
         rf_rd_en_r   <= 1'b0;
         alu_en_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         addr_r       <= addr_nxt_s;
         alu_fun_r    <= fun_nxt_s;
         rf_addr_r    <= rf_addr_s;
         rf_wr_data_r <= wr_data_s;
         rf_wr_en_r   <= wr_en_s;
         rf_rd_en_r   <= rd_en_s;
         alu_en_r     <= alu_en_s;
         busy_r       <= (state_nxt_s != IDLE);
      end
   end

   sys_ctrl_tx_ser u_tx_ser (
      .CLK        (CLK),
      .RST        (RST),
      .start_s    (ser_start_s),
      .two_byte_s (ser_two_s),
      .payload_s  (ser_payload_s),
      .tx_ready_s (bus.TX_READY),
      .tx_data_r  (bus.TX_DATA),
      .tx_valid_r (bus.TX_VALID),
      .hs_s       (ser_hs_s)
   );

   assign bus.RF_ADDR    = rf_addr_r;
   assign bus.RF_WR_EN   = rf_wr_en_r;
   assign bus.RF_WR_DATA = rf_wr_data_r;
   assign bus.RF_RD_EN   = rf_rd_en_r;
   assign bus.ALU_EN     = alu_en_r;
   assign bus.ALU_FUN    = alu_fun_r;
   assign bus.BUSY       = busy_r;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl with a small register-file and 1-cycle ALU model.
module tb_sys_ctrl;
   import UART_pkg::*;

   logic CLK;
   logic RST;
   sys_ctrl_if #(.ADDR_WIDTH(4)) bus ();

   sys_ctrl #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0] rf_m [16];
   int         wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, excl_err = 0;
   logic [3:0] last_wr_addr = 4'd0, last_rd_addr = 4'd0;
   logic [7:0] last_wr_data = 8'd0;
   logic [3:0] last_alu_fun = 4'd0;
   logic [7:0] tx_q [$];

   // Register file and ALU models, both with one cycle of latency.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bus.RF_RD_VALID   <= 1'b0;
         bus.RF_RD_DATA    <= 8'h00;
         bus.ALU_OUT_VALID <= 1'b0;
         bus.ALU_OUT       <= 16'h0000;
      end else begin
         if (bus.RF_WR_EN) rf_m[bus.RF_ADDR] <= bus.RF_WR_DATA;
         bus.RF_RD_VALID <= bus.RF_RD_EN;
         if (bus.RF_RD_EN) bus.RF_RD_DATA <= rf_m[bus.RF_ADDR];
         bus.ALU_OUT_VALID <= bus.ALU_EN;
         if (bus.ALU_EN) begin
            case (bus.ALU_FUN)
               Addition:       bus.ALU_OUT <= {8'h00, rf_m[0]} + {8'h00, rf_m[1]};
               Multiplication: bus.ALU_OUT <= {8'h00, rf_m[0]} * {8'h00, rf_m[1]};
               default:        bus.ALU_OUT <= 16'h0000;
            endcase
         end
      end
   end

   // Output monitor sampled mid-cycle.
   always @(negedge CLK) begin
      if (bus.RF_WR_EN) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= bus.RF_ADDR;
         last_wr_data <= bus.RF_WR_DATA;
      end
      if (bus.RF_RD_EN) begin
         rd_cnt       <= rd_cnt + 1;
         last_rd_addr <= bus.RF_ADDR;
      end
      if (bus.ALU_EN) begin
         alu_cnt      <= alu_cnt + 1;
         last_alu_fun <= bus.ALU_FUN;
      end
      if ((int'(bus.RF_WR_EN) + int'(bus.RF_RD_EN) + int'(bus.ALU_EN)) > 1)
         excl_err <= excl_err + 1;
      if (bus.TX_VALID && bus.TX_READY) tx_q.push_back(bus.TX_DATA);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      @(posedge CLK); #1;
      bus.RX_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.BUSY && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk(tag, {31'd0, bus.BUSY}, 32'd0);
   endtask

   initial begin
      int n;
      logic stable;
      RST = 1'b0;
      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b0;
      bus.TX_READY = 1'b1;
      idle(3);
      chk("rst_busy",    {31'd0, bus.BUSY},     32'd0);
      chk("rst_txv",     {31'd0, bus.TX_VALID}, 32'd0);
      chk("rst_wren",    {31'd0, bus.RF_WR_EN}, 32'd0);
      chk("rst_aluen",   {31'd0, bus.ALU_EN},   32'd0);
      chk("rst_alufun",  {28'd0, bus.ALU_FUN},  32'd0);
      chk("rst_rfaddr",  {28'd0, bus.RF_ADDR},  32'd0);
      RST = 1'b1;
      idle(1);

      // 1: register write
      send(8'hAA); send(8'h05); send(8'h3C); idle(2);
      chk("wr_cnt",  wr_cnt, 32'd1);
      chk("wr_addr", {28'd0, last_wr_addr}, 32'd5);
      chk("wr_data", {24'd0, last_wr_data}, 32'h3C);
      chk("wr_notx", tx_q.size(), 32'd0);

      // 2: register read back over TX
      send(8'hBB); send(8'h05);
      wait_idle("rd_done");
      chk("rd_cnt",  rd_cnt, 32'd1);
      chk("rd_addr", {28'd0, last_rd_addr}, 32'd5);
      chk("rd_txn",  tx_q.size(), 32'd1);
      chk("rd_byte", {24'd0, tx_q[0]}, 32'h3C);

      // 3: multiply 0x0A * 0x03
      send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
      wait_idle("op_done");
      chk("op_wrcnt", wr_cnt, 32'd3);
      chk("op_rf0",   {24'd0, rf_m[0]}, 32'h0A);
      chk("op_rf1",   {24'd0, rf_m[1]}, 32'h03);
      chk("op_alucnt", alu_cnt, 32'd1);
      chk("op_fun",   {28'd0, last_alu_fun}, 32'd2);
      chk("op_txn",   tx_q.size(), 32'd3);
      chk("op_lo",    {24'd0, tx_q[1]}, 32'h1E);
      chk("op_hi",    {24'd0, tx_q[2]}, 32'h00);

      // 4: invalid function code, then a stray byte in IDLE
      send(8'hDD); send(8'h0F); idle(3);
      chk("bad_alucnt", alu_cnt, 32'd1);
      chk("bad_txn",    tx_q.size(), 32'd3);
      chk("bad_busy",   {31'd0, bus.BUSY}, 32'd0);
      chk("bad_fun",    {28'd0, bus.ALU_FUN}, 32'd2);
      send(8'h55);
      chk("ign_busy",   {31'd0, bus.BUSY}, 32'd0);
      idle(2);
      chk("ign_wr",     wr_cnt, 32'd3);
      chk("ign_rd",     rd_cnt, 32'd1);

      // 5: TX back-pressure during TX_LO (0x0A + 0x03)
      bus.TX_READY = 1'b0;
      send(8'hDD); send(8'h00);
      n = 0;
      while (!bus.TX_VALID && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("bp_txv", {31'd0, bus.TX_VALID}, 32'd1);
      stable = 1'b1;
      repeat (20) begin
         @(posedge CLK); #1;
         if (!bus.TX_VALID || bus.TX_DATA !== 8'h0D) stable = 1'b0;
      end
      chk("bp_stable", {31'd0, stable}, 32'd1);
      chk("bp_notx",   tx_q.size(), 32'd3);
      bus.TX_READY = 1'b1;
      wait_idle("bp_done");
      chk("bp_txn", tx_q.size(), 32'd5);
      chk("bp_lo",  {24'd0, tx_q[3]}, 32'h0D);
      chk("bp_hi",  {24'd0, tx_q[4]}, 32'h00);

      // 5b: reset in the middle of a write frame
      send(8'hAA); send(8'h05);
      RST = 1'b0;
      #1;
      chk("mrst_busy",  {31'd0, bus.BUSY},       32'd0);
      chk("mrst_wren",  {31'd0, bus.RF_WR_EN},   32'd0);
      chk("mrst_wdata", {24'd0, bus.RF_WR_DATA}, 32'd0);
      chk("mrst_fun",   {28'd0, bus.ALU_FUN},    32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      send(8'h3C); idle(2);
      chk("mrst_nowr", wr_cnt, 32'd3);
      chk("mrst_idle", {31'd0, bus.BUSY}, 32'd0);

      // 6: silence after a command byte
      send(8'hAA); idle(20);
`ifdef SYS_CTRL_TIMEOUT_EN
      chk("tmo_idle", {31'd0, bus.BUSY}, 32'd0);
      send(8'hAA);
`else
      chk("tmo_wait", {31'd0, bus.BUSY}, 32'd1);
`endif
      send(8'h01); send(8'hFF); idle(2);
      chk("tmo_wrcnt", wr_cnt, 32'd4);
      chk("tmo_addr",  {28'd0, last_wr_addr}, 32'd1);
      chk("tmo_data",  {24'd0, last_wr_data}, 32'hFF);
      chk("excl",      excl_err, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
